mii_loopback_phy: RTL and testbench

//  PHY-side counterpart of the MAC's MII transmit/receive path: sinks the nibble stream the
//  MAC drives on txd/txen, checks it (preamble, SFD, length, CRC-32), buffers one frame and

---
 rtl/mii_loopback_phy.sv | 151 +++++++++++++++
 tb/tb_mii_loopback_phy.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mii_loopback_phy.sv
// mii_loopback_phy: MII PHY model that checks one MAC frame (preamble, SFD, length, CRC-32) and replays it
//  phy_clk, reset (async active-low) | mac_txd/mac_txen/mac_txer: nibble stream from MAC
//  loop_en: replay good frames | phy_rxd/phy_rxen/phy_rxer: replayed stream toward MAC
//  frame_ok/frame_bad: check pulses | crc_err_cnt/drop_cnt: saturating counters | busy: frame held for replay
module mii_loopback_phy #(
  parameter int BUF_AW  = 12,
  parameter int IFG_NIB = 24,
  parameter int MIN_NIB = 128
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic [3:0]  mac_txd,
  input  logic        mac_txen,
  input  logic        mac_txer,
  input  logic        loop_en,
  output logic [3:0]  phy_rxd,
  output logic        phy_rxen,
  output logic        phy_rxer,
  output logic        frame_ok,
  output logic        frame_bad,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt,
  output logic        busy
);
  localparam int PW = BUF_AW + 1;
  localparam int IW = $clog2(IFG_NIB + 1);
  localparam int MW = PW > IW ? PW : IW;
  localparam int CW = MW > 4 ? MW : 4;
  typedef enum logic [2:0] {C_IDLE, C_PRE, C_DATA, C_SKIP, C_DROP, C_CHECK} cap_t;
  typedef enum logic [1:0] {P_IDLE, P_IFG, P_PRE, P_DATA} rep_t;
  cap_t c_q;
  rep_t p_q;
  logic [3:0]    mem [2**BUF_AW];
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   crc_q, crc_d, crc_rev;
  logic          err_q, ok_q, bad_q, rxen_q, busy_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    rxd_q;
  logic [15:0]   cec_q, drc_q;
  logic          full, we, good, start;
  // reflected CRC-32, one nibble per txen cycle, LSB first
  always_comb begin
    crc_d = crc_q ^ {28'h0, mac_txd};
    for (int i = 0; i < 4; i++) crc_d = crc_d[0] ? (crc_d >> 1) ^ 32'hEDB88320 : crc_d >> 1;
  end
  // the shift-right register holds the residue bit-reversed
  assign crc_rev = {<<{crc_q}};
  assign full    = wr_ptr_q[BUF_AW];
  assign we      = c_q == C_DATA && mac_txen && !full;
  assign good    = !err_q && crc_rev == 32'hC704DD7B && 32'(wr_ptr_q) >= MIN_NIB && !wr_ptr_q[0];
  assign start   = c_q == C_CHECK && good && loop_en;
  always_ff @(posedge phy_clk) if (we) mem[wr_ptr_q[BUF_AW-1:0]] <= mac_txd;
  always_ff @(posedge phy_clk or negedge reset) begin
    if (!reset) begin
      c_q      <= C_IDLE;
      wr_ptr_q <= '0;
      crc_q    <= '1;
      err_q    <= 1'b0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
      cec_q    <= '0;
      drc_q    <= '0;
    end else begin
      ok_q  <= 1'b0;
      bad_q <= 1'b0;
      case (c_q)
        C_IDLE: if (mac_txen) c_q <= mac_txd == 4'h5 ? C_PRE : C_SKIP;
        C_PRE:
          if (!mac_txen) c_q <= C_IDLE;
          else if (mac_txd == 4'hD) begin
            c_q <= busy_q ? C_DROP : C_DATA;
            // a held frame keeps its length and buffer while it replays
            if (!busy_q) begin
              wr_ptr_q <= '0;
              crc_q    <= '1;
              err_q    <= 1'b0;
            end
          end else if (mac_txd != 4'h5) c_q <= C_SKIP;
        C_DATA:
          if (mac_txen) begin
            crc_q <= crc_d;
            if (!full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (mac_txer || full) err_q <= 1'b1;
          end else c_q <= C_CHECK;
        C_CHECK: begin
          ok_q  <= good;
          bad_q <= !good;
          if (!good && cec_q != '1) cec_q <= cec_q + 1'b1;
          c_q   <= C_IDLE;
        end
        C_DROP:
          if (!mac_txen) begin
            if (drc_q != '1) drc_q <= drc_q + 1'b1;
            c_q <= C_IDLE;
          end
        default: if (!mac_txen) c_q <= C_IDLE;
      endcase
    end
  end
  always_ff @(posedge phy_clk or negedge reset) begin
    if (!reset) begin
      p_q    <= P_IDLE;
      cnt_q  <= '0;
      rxd_q  <= '0;
      rxen_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (p_q)
        P_IDLE:
          if (start) begin
            p_q    <= P_IFG;
            cnt_q  <= '0;
            busy_q <= 1'b1;
          end
        P_IFG: begin
          cnt_q <= cnt_q + 1'b1;
          // first preamble nibble leaves with the last idle count
          if (cnt_q == CW'(IFG_NIB - 1)) begin
            p_q    <= P_PRE;
            cnt_q  <= CW'(1);
            rxd_q  <= 4'h5;
            rxen_q <= 1'b1;
          end
        end
        P_PRE: begin
          rxd_q <= cnt_q == CW'(15) ? 4'hD : 4'h5;
          cnt_q <= cnt_q == CW'(15) ? '0 : cnt_q + 1'b1;
          if (cnt_q == CW'(15)) p_q <= P_DATA;
        end
        default:
          if (cnt_q == CW'(wr_ptr_q)) begin
            p_q    <= P_IDLE;
            rxd_q  <= '0;
            rxen_q <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            rxd_q <= mem[cnt_q[BUF_AW-1:0]];
            cnt_q <= cnt_q + 1'b1;
          end
      endcase
    end
  end
  assign phy_rxd     = rxd_q;
  assign phy_rxen    = rxen_q;
  assign phy_rxer    = 1'b0;
  assign frame_ok    = ok_q;
  assign frame_bad   = bad_q;
  assign crc_err_cnt = cec_q;
  assign drop_cnt    = drc_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_mii_loopback_phy.sv
// tb_mii_loopback_phy: randomized frame checks of mii_loopback_phy (default and 128-nibble buffer) against a byte-level model
module tb_mii_loopback_phy;
  localparam int IFG = 24;
  logic clk = 0, rst_n = 0;
  logic [3:0] txd = 0;
  logic txen = 0, txer = 0, loop_en = 0;
  logic [3:0] rxd, rxd7;
  logic rxen, rxen7, rxer, rxer7, ok, ok7, bad, bad7, busy, busy7;
  logic [15:0] cec, cec7, drc, drc7;
  always #5 clk = ~clk;
  mii_loopback_phy dut (
    .phy_clk(clk), .reset(rst_n), .mac_txd(txd), .mac_txen(txen), .mac_txer(txer), .loop_en(loop_en),
    .phy_rxd(rxd), .phy_rxen(rxen), .phy_rxer(rxer), .frame_ok(ok), .frame_bad(bad),
    .crc_err_cnt(cec), .drop_cnt(drc), .busy(busy));
  mii_loopback_phy #(.BUF_AW(7)) dut7 (
    .phy_clk(clk), .reset(rst_n), .mac_txd(txd), .mac_txen(txen), .mac_txer(txer), .loop_en(loop_en),
    .phy_rxd(rxd7), .phy_rxen(rxen7), .phy_rxer(rxer7), .frame_ok(ok7), .frame_bad(bad7),
    .crc_err_cnt(cec7), .drop_cnt(drc7), .busy(busy7));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ok_n = 0, bad_n = 0, ok7_n = 0, bad7_n = 0, ok_at = 0, busy_n = 0, idle_nz = 0;
  logic [3:0] rx_q[$], rx7_q[$];
  int rx_c[$];
  always @(negedge clk) begin
    if (ok) begin ok_n++; ok_at = cyc; end
    if (bad) bad_n++;
    if (ok7) ok7_n++;
    if (bad7) bad7_n++;
    if (busy) busy_n++;
    if (rxen) begin rx_q.push_back(rxd); rx_c.push_back(cyc); end
    else if (rxd != 0) idle_nz++;
    if (rxen7) rx7_q.push_back(rxd7);
    else if (rxd7 != 0) idle_nz++;
    if (rxer || rxer7) idle_nz++;
  end
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  logic [3:0] fr[$], keep[$];
  int er_at = -1, tf = 0, tk = 0;
  int exp_ce = 0, exp_ce7 = 0, exp_dr = 0, exp_dr7 = 0;
  int s_ok, s_bad, s_ok7, s_bad7, s_busy, s_rx, s_rx7;
  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c = '1;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  function automatic bit good_for(input int cap);
    logic [7:0] b[$];
    logic [31:0] f;
    int n = fr.size();
    if (er_at >= 0 || n > cap || n < 128 || n % 2 != 0) return 0;
    for (int i = 0; i < n; i += 2) b.push_back({fr[i+1], fr[i]});
    f = {b[n/2-1], b[n/2-2], b[n/2-3], b[n/2-4]};
    for (int i = 0; i < 4; i++) void'(b.pop_back());
    return crc32(b) == f;
  endfunction
  function automatic logic [3:0] exp_nib(input int i);
    return i < 15 ? 4'h5 : i == 15 ? 4'hD : fr[i-16];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic build(input int nbytes, input int mode);
    logic [7:0] b[$];
    logic [31:0] f;
    int k;
    fr.delete();
    er_at = -1;
    for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
    f = crc32(b);
    for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    foreach (b[i]) begin fr.push_back(b[i][3:0]); fr.push_back(b[i][7:4]); end
    if (mode == 1) begin
      k = $urandom_range(0, 2 * nbytes - 1);
      fr[k] = fr[k] ^ 4'($urandom_range(1, 15));
    end
    if (mode == 2) er_at = $urandom_range(20, fr.size() - 20);
    if (mode == 3) fr.push_back(4'($urandom));
  endtask
  task automatic send();
    for (int i = 0; i < 16; i++) begin tick(); txen = 1; txd = (i == 15) ? 4'hD : 4'h5; end
    foreach (fr[i]) begin tick(); txd = fr[i]; txer = (i == er_at); end
    tick();
    txen = 0; txd = 0; txer = 0;
    tf = cyc + 1;
  endtask
  task automatic snap();
    s_ok = ok_n; s_bad = bad_n; s_ok7 = ok7_n; s_bad7 = bad7_n; s_busy = busy_n;
    s_rx = rx_q.size(); s_rx7 = rx7_q.size();
  endtask
  task automatic verify(input bit g, input bit g7, input bit le);
    int len = fr.size();
    int n = rx_q.size() - s_rx;
    int n7 = rx7_q.size() - s_rx7;
    int mis = 0, mis7 = 0;
    if (!g) exp_ce++;
    if (!g7) exp_ce7++;
    check("ok_pulse", ok_n - s_ok, int'(g));
    check("bad_pulse", bad_n - s_bad, int'(!g));
    check("crc_err_cnt", cec, exp_ce);
    check("drop_cnt", drc, exp_dr);
    check("ok7_pulse", ok7_n - s_ok7, int'(g7));
    check("bad7_pulse", bad7_n - s_bad7, int'(!g7));
    check("crc_err_cnt7", cec7, exp_ce7);
    check("drop_cnt7", drc7, exp_dr7);
    if (g) check("ok_latency", ok_at, tf + 1);
    check("rx_len", n, (g && le) ? 16 + len : 0);
    check("rx7_len", n7, (g7 && le) ? 16 + len : 0);
    check("busy_cycles", busy_n - s_busy, (g && le) ? IFG + 16 + len : 0);
    if (g && le && n == 16 + len) begin
      check("rx_first", rx_c[s_rx], tf + 1 + IFG);
      for (int i = 0; i < n; i++) if (rx_q[s_rx+i] !== exp_nib(i)) mis++;
      check("rx_data", mis, 0);
    end
    if (g7 && le && n7 == 16 + len) begin
      for (int i = 0; i < n7; i++) if (rx7_q[s_rx7+i] !== exp_nib(i)) mis7++;
      check("rx7_data", mis7, 0);
    end
    check("busy_idle", busy, 0);
  endtask
  task automatic run(input int nbytes, input int mode, input bit le);
    bit g, g7;
    build(nbytes, mode);
    g = good_for(4096);
    g7 = good_for(128);
    snap();
    loop_en = le;
    send();
    repeat (IFG + 16 + fr.size() + 12) tick();
    verify(g, g7, le);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    rst_n = 0;
    repeat (3) tick();
    check("rst_rxd", rxd, 0);
    check("rst_rxen", rxen, 0);
    check("rst_rxer", rxer, 0);
    check("rst_ok", ok, 0);
    check("rst_bad", bad, 0);
    check("rst_crc_cnt", cec, 0);
    check("rst_drop_cnt", drc, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    repeat (2) tick();
    run(60, 0, 1);
    run(60, 1, 1);
    run(60, 2, 1);
    run(36, 0, 1);
    run(96, 0, 1);
    run(60, 0, 1);
    build(60, 0);
    snap();
    loop_en = 1;
    send();
    keep = fr;
    tk = tf;
    repeat (3) tick();
    loop_en = 0;
    build(60, 0);
    send();
    fr = keep;
    tf = tk;
    exp_dr++;
    exp_dr7++;
    repeat (IFG + 16 + fr.size() + 12) tick();
    verify(good_for(4096), good_for(128), 1);
    run(60, 0, 0);
    build(60, 0);
    loop_en = 1;
    send();
    repeat (IFG + 16 + 40) tick();
    check("pdata_rxen", rxen, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_rxen", rxen, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rxd", rxd, 0);
    repeat (3) tick();
    rst_n = 1;
    exp_ce = 0; exp_ce7 = 0; exp_dr = 0; exp_dr7 = 0;
    check("async_rst_drop", drc, 0);
    repeat (2) tick();
    run(60, 0, 1);
    for (int i = 0; i < 12; i++) run($urandom_range(36, 70), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    check("rx_idle_quiet", idle_nz, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
